// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared UART definitions: receiver FSM states and default frame
//             geometry, common to the receiver and the future transmitter.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Default clock cycles per bit period (even, >= 4)
  localparam int DEF_CLK_DIV = 16;
  // Default data bits per frame
  localparam int DEF_WIDTH   = 8;

  // Receiver framing states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_e;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_if
//  Purpose  : Consumer-side bundle of the UART receiver: received byte with a
//             valid/ready handshake plus framing-error and overrun pulses.
//  Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_if
  import uart_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic [WIDTH-1:0] dout;       // last received byte, stable while valid=1
  logic             valid;      // dout holds an unconsumed byte
  logic             ready;      // consumer takes dout on valid&ready
  logic             frame_err;  // one-cycle pulse: stop bit sampled low
  logic             overrun;    // one-cycle pulse: good frame dropped

  // Receiver side drives the data and status
  modport master (
    output dout,
    output valid,
    output frame_err,
    output overrun,
    input  ready
  );

  // Consumer side drives ready
  modport slave (
    input  dout,
    input  valid,
    input  frame_err,
    input  overrun,
    output ready
  );

endinterface : uart_rx_if
`default_nettype wire

// File: rtl/uart_sync.sv
`default_nettype none
// ============================================================================
//  Module   : uart_sync
//  Purpose  : Two-flop synchronizer for an asynchronous single-bit input,
//             with a configurable value loaded by the asynchronous reset.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic d_i,
  output logic      q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule : uart_sync
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Purpose  : UART receiver, 8N1-style framing (WIDTH data bits, LSB first),
//             mid-bit sampling with CLK_DIV clocks per bit, single-entry
//             output register with valid/ready handshake, framing-error and
//             overrun pulses.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int WIDTH   = DEF_WIDTH
) (
  input  wire logic  clk,
  input  wire logic  rst,
  input  wire logic  rxd,
  uart_rx_if.master  bus
);

  localparam int TICK_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W  = (WIDTH > 1)   ? $clog2(WIDTH)   : 1;

  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(CLK_DIV/2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);

  logic              rxs;

  uart_state_e       state_q, state_d;
  logic [TICK_W-1:0] tick_q,  tick_d;
  logic [BIT_W-1:0]  bit_q,   bit_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic              done_q,  done_d;   // good stop bit seen at last edge
  logic              ferr_q,  ferr_d;   // bad stop bit seen at last edge

  logic [WIDTH-1:0]  dout_q;
  logic              valid_q;
  logic              ovr_q;

  // Idle-high line: the synchronizer resets to 1 so reset never looks like a start bit
  uart_sync #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rxd),
    .q_o (rxs)
  );

  // Framing state, counters and shift register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state logic: start validation, data shifting and stop-bit check
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q + TICK_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        tick_d = '0;
        if (!rxs) begin
          // The detecting edge itself is tick 0, so the counter reads 1 at
          // the following edge and the start sample lands on CLK_DIV/2-1.
          state_d = START;
          tick_d  = TICK_W'(1);
        end
      end

      START: begin
        if (tick_q == TICK_HALF) begin
          tick_d = '0;
          if (rxs) begin
            state_d = IDLE;       // glitch, not a start bit
          end else begin
            state_d = DATA;
            bit_d   = '0;
          end
        end
      end

      DATA: begin
        if (tick_q == TICK_LAST) begin
          tick_d             = '0;
          shift_d            = shift_q >> 1;
          shift_d[WIDTH-1]   = rxs;   // LSB arrives first, ends up at bit 0
          if (bit_q == BIT_LAST) begin
            state_d = STOP;
            bit_d   = '0;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
          end
        end
      end

      STOP: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (rxs) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = BREAK;
            ferr_d  = 1'b1;
          end
        end
      end

      BREAK: begin
        tick_d = '0;
        if (rxs) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        tick_d  = '0;
      end
    endcase
  end

  // Output register: load a completed byte, flag overrun, or retire on handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (done_q) begin
        if (!valid_q || bus.ready) begin
          dout_q  <= shift_q;
          valid_q <= 1'b1;
        end else begin
          ovr_q   <= 1'b1;        // consumer stalled: keep old byte, drop new
        end
      end else if (valid_q && bus.ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.dout      = dout_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.overrun   = ovr_q;

endmodule : uart_rx
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx
//  Purpose  : Scoreboard bench for uart_rx (CLK_DIV=16, WIDTH=8): directed
//             frames push expected events, a monitor pops them on handshakes
//             and error/overrun pulses.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int CLK_DIV = 16;
  localparam int WIDTH   = 8;

  localparam int K_BYTE = 0;
  localparam int K_FERR = 1;
  localparam int K_OVR  = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rxd = 1'b1;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  uart_rx_if #(.WIDTH(WIDTH)) bus ();

  uart_rx #(
    .CLK_DIV (CLK_DIV),
    .WIDTH   (WIDTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .rxd (rxd),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic expect_event(input int kind, input logic [7:0] data, input string name);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s unexpected event: actual_data=%02h required=none", name, data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || (kind == K_BYTE && e.data !== data)) begin
        failures++;
        $display("FAIL %s actual_kind=%0d actual_data=%02h required_kind=%0d required_data=%02h",
                 name, kind, data, e.kind, e.data);
      end
    end
  endtask

  // Monitor: compare every consumed byte and every status pulse to the queue
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.frame_err || bus.overrun)
        check("err_ovr_exclusive", 32'(bus.frame_err & bus.overrun), 32'd0);
      if (bus.valid && bus.ready)
        expect_event(K_BYTE, bus.dout, "byte");
      if (bus.frame_err)
        expect_event(K_FERR, 8'h00, "frame_err");
      if (bus.overrun)
        expect_event(K_OVR, 8'h00, "overrun");
    end
  end

  task automatic send_bit(input logic v);
    rxd = v;
    repeat (CLK_DIV) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_v);
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Watchdog: the stimulus never waits on the DUT, but bound the run anyway
  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog timeout reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ready = 1'b1;

    // Asynchronous reset takes effect before any clock edge
    #1 rst = 1'b1;
    #1;
    check("reset_dout",      32'(bus.dout),      32'h0);
    check("reset_valid",     32'(bus.valid),     32'h0);
    check("reset_frame_err", 32'(bus.frame_err), 32'h0);
    check("reset_overrun",   32'(bus.overrun),   32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(4);

    // 0xA5 with ready=1: stop sample at t0+151, valid at t0+152, gone at t0+153
    // (drive edge E0 = t0-3 due to the two synchronizer flops)
    exp_q.push_back('{K_BYTE, 8'hA5});
    fork
      send_frame(8'hA5, 1'b1);
      begin
        repeat (154) @(posedge clk);
        #1 check("a5_valid_before", 32'(bus.valid), 32'h0);
        @(posedge clk);
        #1 check("a5_valid_at",     32'(bus.valid), 32'h1);
        check("a5_dout_at",         32'(bus.dout),  32'hA5);
        @(posedge clk);
        #1 check("a5_valid_after",  32'(bus.valid), 32'h0);
      end
    join
    idle(20);

    // 5-cycle low glitch is rejected at the start sample
    rxd = 1'b0;
    repeat (5) @(posedge clk);
    #1 rxd = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("glitch_state", 32'(dut.state_q), 32'(uart_pkg::IDLE));
    check("glitch_valid", 32'(bus.valid),   32'h0);
    idle(20);

    // 0x3C with low stop bit -> one frame_err pulse, then 0x81 received
    exp_q.push_back('{K_FERR, 8'h00});
    send_frame(8'h3C, 1'b0);
    idle(20);
    check("break_left_state", 32'(dut.state_q), 32'(uart_pkg::IDLE));
    exp_q.push_back('{K_BYTE, 8'h81});
    send_frame(8'h81, 1'b1);
    idle(20);

    // 0x11 then 0x22 back-to-back with ready=0 -> overrun, 0x11 kept
    bus.ready = 1'b0;
    exp_q.push_back('{K_OVR,  8'h00});
    exp_q.push_back('{K_BYTE, 8'h11});
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(5);
    check("ovr_dout_held",  32'(bus.dout),  32'h11);
    check("ovr_valid_held", 32'(bus.valid), 32'h1);
    bus.ready = 1'b1;
    @(posedge clk);
    #1 bus.ready = 1'b0;
    check("ovr_valid_drop", 32'(bus.valid), 32'h0);
    check("ovr_dout_keep",  32'(bus.dout),  32'h11);
    idle(10);

    // 0x22 completes on the same edge that 0x11 is consumed -> no overrun
    exp_q.push_back('{K_BYTE, 8'h11});
    exp_q.push_back('{K_BYTE, 8'h22});
    send_frame(8'h11, 1'b1);
    fork
      send_frame(8'h22, 1'b1);
      begin
        repeat (154) @(posedge clk);
        #1 bus.ready = 1'b1;
        check("same_edge_dout_old", 32'(bus.dout), 32'h11);
        @(posedge clk);
        #1;
        check("same_edge_valid",    32'(bus.valid),   32'h1);
        check("same_edge_dout_new", 32'(bus.dout),    32'h22);
        check("same_edge_no_ovr",   32'(bus.overrun), 32'h0);
      end
    join
    idle(10);

    // Reset in the middle of 0xFF abandons it; 0x5A afterwards is clean
    bus.ready = 1'b1;
    rxd = 1'b0;
    repeat (CLK_DIV) @(posedge clk);
    #1 rxd = 1'b1;
    repeat (47) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_state", 32'(dut.state_q), 32'(uart_pkg::IDLE));
    check("midrst_dout",  32'(bus.dout),    32'h0);
    repeat (10) @(posedge clk);
    #1 rst = 1'b0;
    idle(120);
    check("midrst_no_valid", 32'(bus.valid), 32'h0);
    exp_q.push_back('{K_BYTE, 8'h5A});
    send_frame(8'h5A, 1'b1);
    idle(20);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_uart_rx
`default_nettype wire
